// File: rtl/multicycle_control_fsm.sv
// Multicycle main control FSM: sequences fetch/decode/execute/memory/writeback,
// drives shared-ALU/shared-memory datapath controls, handles memory wait
// states with an optional timeout, and traps on illegal opcodes or timeouts.
module multicycle_control_fsm #(
  parameter int unsigned EXT_OPS     = 1,
  parameter int unsigned MEM_WAIT    = 1,
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [1:0] ALUOp,
  output logic       RegWrite,
  output logic       Branch,
  output logic       fault,
  output logic [1:0] fault_cause,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11,
    S_AUIPC    = 4'd12,
    S_TRAP     = 4'd15
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       adr_src;
    logic       mem_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       branch;
    logic       pc_update;
  } ctrl_t;

  localparam logic [6:0] OP_LW    = 7'd3;
  localparam logic [6:0] OP_SW    = 7'd35;
  localparam logic [6:0] OP_R     = 7'd51;
  localparam logic [6:0] OP_ADDI  = 7'd19;
  localparam logic [6:0] OP_BEQ   = 7'd99;
  localparam logic [6:0] OP_JAL   = 7'd111;
  localparam logic [6:0] OP_LUI   = 7'd55;
  localparam logic [6:0] OP_AUIPC = 7'd23;

  localparam logic ext_ok = (EXT_OPS != 0);

  state_t           state;
  state_t           nxt;
  ctrl_t            ctrl;
  logic [CNT_W-1:0] wait_cnt;
  logic [1:0]       cause_nxt;
  logic             ready_eff;
  logic             timeout_hit;

  // Moore control values per state; FETCH's IRWrite/PCUpdate depend on
  // mem_ready and are produced combinationally below.
  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:    begin c.mem_req = 1'b1; c.alu_src_b = 2'b10; c.result_src = 2'b10; end
      S_DECODE:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
      S_MEMADR:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
      S_MEMREAD:  begin c.mem_req = 1'b1; c.adr_src = 1'b1; end
      S_MEMWB:    begin c.result_src = 2'b01; c.reg_write = 1'b1; end
      S_MEMWRITE: begin c.mem_req = 1'b1; c.adr_src = 1'b1; c.mem_write = 1'b1; end
      S_EXECR:    begin c.alu_src_a = 2'b10; c.alu_op = 2'b10; end
      S_EXECI:    begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = 2'b10; end
      S_ALUWB:    begin c.reg_write = 1'b1; end
      S_BEQ:      begin c.alu_src_a = 2'b10; c.alu_op = 2'b01; c.branch = 1'b1; end
      S_JAL:      begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_update = 1'b1; end
      S_LUI:      begin c.alu_src_a = 2'b11; c.alu_src_b = 2'b01; end
      S_AUIPC:    begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
      default:    c = '0;
    endcase
    return c;
  endfunction

  assign ready_eff   = (MEM_WAIT == 0) ? 1'b1 : mem_ready;
  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == CNT_W'(MEM_TIMEOUT)) && !ready_eff;

  // Next-state and trap-cause selection.
  always_comb begin
    nxt       = state;
    cause_nxt = fault_cause;
    case (state)
      S_FETCH:    if (ready_eff) nxt = S_DECODE;
      S_DECODE: begin
        nxt       = S_TRAP;
        cause_nxt = 2'b10;
        if (opcode == OP_LW || opcode == OP_SW) begin
          nxt = S_MEMADR; cause_nxt = fault_cause;
        end else if (opcode == OP_R) begin
          nxt = S_EXECR; cause_nxt = fault_cause;
        end else if (opcode == OP_ADDI) begin
          nxt = S_EXECI; cause_nxt = fault_cause;
        end else if (opcode == OP_BEQ) begin
          nxt = S_BEQ; cause_nxt = fault_cause;
        end else if (opcode == OP_JAL) begin
          nxt = S_JAL; cause_nxt = fault_cause;
        end else if (ext_ok && opcode == OP_LUI) begin
          nxt = S_LUI; cause_nxt = fault_cause;
        end else if (ext_ok && opcode == OP_AUIPC) begin
          nxt = S_AUIPC; cause_nxt = fault_cause;
        end
      end
      S_MEMADR:   nxt = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (ready_eff) nxt = S_MEMWB;
      S_MEMWB:    nxt = S_FETCH;
      S_MEMWRITE: if (ready_eff) nxt = S_FETCH;
      S_EXECR:    nxt = S_ALUWB;
      S_EXECI:    nxt = S_ALUWB;
      S_ALUWB:    nxt = S_FETCH;
      S_BEQ:      nxt = S_FETCH;
      S_JAL:      nxt = S_ALUWB;
      S_LUI:      nxt = S_ALUWB;
      S_AUIPC:    nxt = S_ALUWB;
      S_TRAP:     nxt = S_TRAP;
      default:    nxt = S_FETCH;
    endcase
    if (ctrl.mem_req && timeout_hit) begin
      nxt       = S_TRAP;
      cause_nxt = 2'b01;
    end
  end

  // State, wait counter, sticky fault, and Moore outputs registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_FETCH;
      wait_cnt    <= '0;
      fault       <= 1'b0;
      fault_cause <= '0;
      ctrl        <= decode_ctrl(S_FETCH);
    end else begin
      state       <= nxt;
      fault_cause <= cause_nxt;
      fault       <= (nxt == S_TRAP);
      ctrl        <= decode_ctrl(nxt);
      if (nxt != state)
        wait_cnt <= '0;
      else if (ctrl.mem_req && !ready_eff)
        wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // Output drive; input-dependent write strobes are suppressed while rst is high.
  always_comb begin
    mem_req   = ctrl.mem_req;
    AdrSrc    = ctrl.adr_src;
    MemWrite  = ctrl.mem_write;
    ResultSrc = ctrl.result_src;
    ALUSrcA   = ctrl.alu_src_a;
    ALUSrcB   = ctrl.alu_src_b;
    ALUOp     = ctrl.alu_op;
    RegWrite  = ctrl.reg_write;
    Branch    = ctrl.branch;
    IRWrite   = (state == S_FETCH) && ready_eff && !rst;
    PCWrite   = !rst && (((state == S_FETCH) && ready_eff) || ctrl.pc_update ||
                         (ctrl.branch && zero));
    state_dbg = state;
  end

  // Immediate format select, decoded from opcode in every state.
  always_comb begin
    ImmSrc = 3'b000;
    case (opcode)
      OP_LW, OP_ADDI:  ImmSrc = 3'b000;
      OP_SW:           ImmSrc = 3'b001;
      OP_BEQ:          ImmSrc = 3'b010;
      OP_JAL:          ImmSrc = 3'b011;
      OP_LUI, OP_AUIPC: ImmSrc = ext_ok ? 3'b100 : 3'b000;
      default:         ImmSrc = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: two instances (extended ops with a short
// timeout, and base ops with no memory waiting) checked every cycle against a
// route-based instruction model, plus directed literal expectations.
module tb_multicycle_control_fsm;

  typedef struct packed {
    logic       mreq;
    logic       pcw;
    logic       adr;
    logic       mw;
    logic       irw;
    logic [1:0] rs;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [2:0] imm;
    logic [1:0] aop;
    logic       rw;
    logic       br;
    logic       flt;
    logic [1:0] fc;
    logic [3:0] sd;
  } outs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'd3;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;

  int checks = 0;
  int errors = 0;

  // instance 0: EXT_OPS=1, MEM_WAIT=1, MEM_TIMEOUT=4 ; instance 1: EXT_OPS=0, MEM_WAIT=0, MEM_TIMEOUT=255
  int p_ext[2]  = '{1, 0};
  int p_wait[2] = '{1, 0};
  int p_to[2]   = '{4, 255};

  logic mem_req_a, PCWrite_a, AdrSrc_a, MemWrite_a, IRWrite_a, RegWrite_a, Branch_a, fault_a;
  logic [1:0] ResultSrc_a, ALUSrcA_a, ALUSrcB_a, ALUOp_a, fault_cause_a;
  logic [2:0] ImmSrc_a;
  logic [3:0] state_dbg_a;
  logic mem_req_b, PCWrite_b, AdrSrc_b, MemWrite_b, IRWrite_b, RegWrite_b, Branch_b, fault_b;
  logic [1:0] ResultSrc_b, ALUSrcA_b, ALUSrcB_b, ALUOp_b, fault_cause_b;
  logic [2:0] ImmSrc_b;
  logic [3:0] state_dbg_b;

  multicycle_control_fsm #(.EXT_OPS(1), .MEM_WAIT(1), .MEM_TIMEOUT(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req_a), .PCWrite(PCWrite_a), .AdrSrc(AdrSrc_a), .MemWrite(MemWrite_a),
    .IRWrite(IRWrite_a), .ResultSrc(ResultSrc_a), .ALUSrcA(ALUSrcA_a), .ALUSrcB(ALUSrcB_a),
    .ImmSrc(ImmSrc_a), .ALUOp(ALUOp_a), .RegWrite(RegWrite_a), .Branch(Branch_a),
    .fault(fault_a), .fault_cause(fault_cause_a), .state_dbg(state_dbg_a)
  );

  multicycle_control_fsm #(.EXT_OPS(0), .MEM_WAIT(0), .MEM_TIMEOUT(255), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req_b), .PCWrite(PCWrite_b), .AdrSrc(AdrSrc_b), .MemWrite(MemWrite_b),
    .IRWrite(IRWrite_b), .ResultSrc(ResultSrc_b), .ALUSrcA(ALUSrcA_b), .ALUSrcB(ALUSrcB_b),
    .ImmSrc(ImmSrc_b), .ALUOp(ALUOp_b), .RegWrite(RegWrite_b), .Branch(Branch_b),
    .fault(fault_b), .fault_cause(fault_cause_b), .state_dbg(state_dbg_b)
  );

  outs_t got[2];
  assign got[0] = {mem_req_a, PCWrite_a, AdrSrc_a, MemWrite_a, IRWrite_a, ResultSrc_a,
                   ALUSrcA_a, ALUSrcB_a, ImmSrc_a, ALUOp_a, RegWrite_a, Branch_a,
                   fault_a, fault_cause_a, state_dbg_a};
  assign got[1] = {mem_req_b, PCWrite_b, AdrSrc_b, MemWrite_b, IRWrite_b, ResultSrc_b,
                   ALUSrcA_b, ALUSrcB_b, ImmSrc_b, ALUOp_b, RegWrite_b, Branch_b,
                   fault_b, fault_cause_b, state_dbg_b};

  always #5 clk = ~clk;

  // Model: each opcode follows a fixed route of states; memory states may stall.
  function automatic int route_len(input logic [6:0] op, input bit ext);
    case (op)
      7'd3:                      return 5;
      7'd35, 7'd51, 7'd19, 7'd111: return 4;
      7'd55, 7'd23:              return ext ? 4 : 3;
      default:                   return 3;
    endcase
  endfunction

  function automatic int route_at(input logic [6:0] op, input bit ext, input int idx);
    if (idx == 0) return 0;
    if (idx == 1) return 1;
    if (idx == 2) begin
      case (op)
        7'd3, 7'd35: return 2;
        7'd51:       return 6;
        7'd19:       return 7;
        7'd99:       return 9;
        7'd111:      return 10;
        7'd55:       return ext ? 11 : 15;
        7'd23:       return ext ? 12 : 15;
        default:     return 15;
      endcase
    end
    if (idx == 3) return (op == 7'd3) ? 3 : (op == 7'd35) ? 5 : 8;
    return 4;
  endfunction

  function automatic outs_t model_out(input int st, input bit rdy, input bit z,
                                      input logic [6:0] op, input bit ext,
                                      input int cause, input bit r);
    outs_t o;
    o = '0;
    case (st)
      0:  begin o.mreq = 1; o.rs = 2; o.sb = 2; o.irw = rdy && !r; o.pcw = rdy && !r; end
      1:  begin o.sa = 1; o.sb = 1; end
      2:  begin o.sa = 2; o.sb = 1; end
      3:  begin o.mreq = 1; o.adr = 1; end
      4:  begin o.rs = 1; o.rw = 1; end
      5:  begin o.mreq = 1; o.adr = 1; o.mw = 1; end
      6:  begin o.sa = 2; o.aop = 2; end
      7:  begin o.sa = 2; o.sb = 1; o.aop = 2; end
      8:  begin o.rw = 1; end
      9:  begin o.sa = 2; o.aop = 1; o.br = 1; o.pcw = z && !r; end
      10: begin o.sa = 1; o.sb = 2; o.pcw = !r; end
      11: begin o.sa = 3; o.sb = 1; end
      12: begin o.sa = 1; o.sb = 1; end
      15: begin o.flt = 1; end
      default: o = '0;
    endcase
    case (op)
      7'd35:        o.imm = 3'd1;
      7'd99:        o.imm = 3'd2;
      7'd111:       o.imm = 3'd3;
      7'd55, 7'd23: o.imm = ext ? 3'd4 : 3'd0;
      default:      o.imm = 3'd0;
    endcase
    o.fc = cause[1:0];
    o.sd = st[3:0];
    return o;
  endfunction

  int m_st[2]    = '{0, 0};
  int m_idx[2]   = '{0, 0};
  int m_wcnt[2]  = '{0, 0};
  int m_cause[2] = '{0, 0};

  // Model state advance.
  always @(posedge clk or posedge rst) begin : mdl
    int st, idx, w, c;
    bit rdy, ext;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_st[k] <= 0; m_idx[k] <= 0; m_wcnt[k] <= 0; m_cause[k] <= 0;
      end else begin
        st = m_st[k]; idx = m_idx[k]; w = m_wcnt[k]; c = m_cause[k];
        rdy = (p_wait[k] == 0) || mem_ready;
        ext = (p_ext[k] != 0);
        if (st == 15) begin
          // stuck until reset
        end else if ((st == 0 || st == 3 || st == 5) && !rdy) begin
          if (p_to[k] != 0 && w == p_to[k]) begin
            st = 15; c = 1; w = 0;
          end else begin
            w = w + 1;
          end
        end else begin
          idx = idx + 1;
          if (idx >= route_len(opcode, ext)) idx = 0;
          st = route_at(opcode, ext, idx);
          if (st == 15) c = 2;
          w = 0;
        end
        m_st[k] <= st; m_idx[k] <= idx; m_wcnt[k] <= w; m_cause[k] <= c;
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    outs_t e;
    for (int k = 0; k < 2; k++) begin
      e = model_out(m_st[k], (p_wait[k] == 0) || mem_ready, zero, opcode,
                    p_ext[k] != 0, m_cause[k], rst);
      checks++;
      if (got[k] !== e) begin
        errors++;
        $display("FAIL model_%s t=%0t got=%h expected=%h", (k == 0) ? "a" : "b", $time, got[k], e);
      end
    end
  end

  task automatic chk(input string name, input int gv, input int ev);
    checks++;
    if (gv != ev) begin
      errors++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, gv, ev);
    end
  endtask

  task automatic do_reset(input logic [6:0] op, input logic rdy, input logic z);
    @(posedge clk); #1;
    rst = 1'b1; opcode = op; mem_ready = rdy; zero = z;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  int lw_seq[6]  = '{0, 1, 2, 3, 4, 0};
  int sw_seq[8]  = '{0, 1, 2, 5, 5, 5, 5, 0};
  int sw_rdy[8]  = '{1, 1, 1, 0, 0, 0, 1, 1};
  int lui_seq[5] = '{0, 1, 11, 8, 0};
  int jal_seq[4] = '{0, 1, 10, 8};
  int beq_seq[4] = '{0, 1, 9, 0};
  logic [6:0] mix_ops[7] = '{7'd51, 7'd19, 7'd3, 7'd35, 7'd99, 7'd111, 7'd23};
  int mix_rdy[7] = '{1, 0, 1, 1, 0, 1, 1};

  initial begin
    // reset state
    @(negedge clk);
    chk("reset_state", state_dbg_a, 0);
    chk("reset_fault", fault_a, 0);
    chk("reset_cause", fault_cause_a, 0);
    chk("reset_mem_req", mem_req_a, 1);
    chk("reset_regwrite", RegWrite_a, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // lw with no wait states
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("lw_state", state_dbg_a, lw_seq[i]);
      chk("lw_regwrite", RegWrite_a, (i == 4) ? 1 : 0);
      if (i == 4) chk("lw_resultsrc", ResultSrc_a, 1);
      @(posedge clk); #1;
    end

    // sw with three wait cycles in MEMWRITE
    do_reset(7'd35, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      mem_ready = sw_rdy[i][0];
      @(negedge clk);
      chk("sw_state", state_dbg_a, sw_seq[i]);
      chk("sw_memwrite", MemWrite_a, (sw_seq[i] == 5) ? 1 : 0);
      chk("sw_immsrc", ImmSrc_a, 1);
      @(posedge clk); #1;
    end

    // beq taken and not taken
    for (int t = 0; t < 2; t++) begin
      do_reset(7'd99, 1'b1, (t == 0) ? 1'b1 : 1'b0);
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        chk("beq_state", state_dbg_a, beq_seq[i]);
        if (i == 2) chk("beq_pcwrite", PCWrite_a, (t == 0) ? 1 : 0);
        @(posedge clk); #1;
      end
    end

    // memory timeout in FETCH
    do_reset(7'd3, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i >= 6) mem_ready = 1'b1;
      @(negedge clk);
      chk("to_state", state_dbg_a, (i < 5) ? 0 : 15);
      if (i >= 5) begin
        chk("to_fault", fault_a, 1);
        chk("to_cause", fault_cause_a, 1);
        chk("to_regwrite", RegWrite_a, 0);
      end
      @(posedge clk); #1;
    end
    do_reset(7'd3, 1'b1, 1'b0);
    @(negedge clk);
    chk("to_reset_state", state_dbg_a, 0);
    chk("to_reset_fault", fault_a, 0);
    @(posedge clk); #1;

    // lui: decoded on instance a, illegal on instance b
    do_reset(7'd55, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("lui_state", state_dbg_a, lui_seq[i]);
      chk("lui_immsrc", ImmSrc_a, 4);
      if (i == 2) begin
        chk("lui_alusrca", ALUSrcA_a, 3);
        chk("lui_b_state", state_dbg_b, 15);
        chk("lui_b_cause", fault_cause_b, 2);
        chk("lui_b_fault", fault_b, 1);
        chk("lui_b_immsrc", ImmSrc_b, 0);
      end
      @(posedge clk); #1;
    end

    // jal, with an asynchronous reset pulse during ALUWB
    do_reset(7'd111, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("jal_state", state_dbg_a, jal_seq[i]);
      if (i == 2) chk("jal_pcwrite", PCWrite_a, 1);
      if (i == 3) chk("jal_regwrite", RegWrite_a, 1);
      if (i == 3) begin
        #1 rst = 1'b1;
        #1;
        chk("jal_rst_state", state_dbg_a, 0);
        chk("jal_rst_regwrite", RegWrite_a, 0);
        chk("jal_rst_irwrite", IRWrite_a, 0);
        chk("jal_rst_pcwrite", PCWrite_a, 0);
        #1 rst = 1'b0;
      end
      @(posedge clk); #1;
    end

    // mixed opcodes with a fixed ready pattern, checked by the model only
    for (int j = 0; j < 7; j++) begin
      do_reset(mix_ops[j], 1'b1, 1'b1);
      for (int i = 0; i < 7; i++) begin
        mem_ready = mix_rdy[i][0];
        @(posedge clk); #1;
      end
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Multicycle successor to the single-cycle main decoder. It sequences each instruction through fetch, decode, execute, memory and writeback states, and drives the shared-ALU/shared-memory datapath controls. Relative to the single-cycle decoder it adds:
- a memory ready handshake with wait states;
- a configurable timeout;
- optional lui/auipc support;
- illegal-opcode and timeout trapping.

Parameters:
- EXT_OPS, 1: 1 = decode lui (7'd55) and auipc (7'd23); 0 = treat them as illegal.
- MEM_WAIT, 1: 1 = honour mem_ready; 0 = treat mem_ready as constant 1.
- MEM_TIMEOUT, 255: maximum wait cycles per memory access before trapping; 0 = timeout disabled.
- CNT_W, 8: width of the wait counter; must satisfy MEM_TIMEOUT < 2^CNT_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- opcode  in  7  instr[6:0] from the instruction register; stable from DECODE onward.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access requested (FETCH, MEMREAD, MEMWRITE).
- PCWrite  out  1  PCUpdate | (Branch & zero).
- AdrSrc  out  1  0 = PC, 1 = ALUOut.
- MemWrite  out  1  store strobe.
- IRWrite  out  1  latch instruction and OldPC.
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1, 11 = zero.
- ALUSrcB  out  2  00 = rs2, 01 = imm, 10 = constant 4.
- ImmSrc  out  3  000 = I, 001 = S, 010 = B, 011 = J, 100 = U.
- ALUOp  out  2  00 = add, 01 = sub/compare, 10 = funct-decoded.
- RegWrite  out  1  register file write enable.
- Branch  out  1  conditional branch state.
- fault  out  1  sticky trap indicator.
- fault_cause  out  2  00 = none, 01 = memory timeout, 10 = illegal opcode.
- state_dbg  out  4  current state encoding.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- On reset: state = FETCH, wait_cnt = 0, fault = 0, fault_cause = 00. Outputs are the FETCH Moore values; all controls not listed for a state are 0.
- State encodings: FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5, EXECR = 6, EXECI = 7, ALUWB = 8, BEQ = 9, JAL = 10, LUI = 11, AUIPC = 12, TRAP = 15.
- ImmSrc is combinational from opcode in every state:
  - lw / addi (7'd19) → 000
  - sw → 001
  - beq → 010
  - jal → 011
  - lui / auipc → 100 (only when EXT_OPS = 1)
  - anything else → 000
- FETCH:
  - Drives mem_req = 1, AdrSrc = 0, ALUSrcA = 00, ALUSrcB = 10, ALUOp = 00, ResultSrc = 10.
  - IRWrite and PCUpdate are asserted only in the cycle mem_ready = 1; FETCH → DECODE in that cycle.
  - Otherwise FETCH holds.
- DECODE:
  - Drives ALUSrcA = 01, ALUSrcB = 01, ALUOp = 00 (branch target into ALUOut).
  - Next state by opcode:
    - lw / sw → MEMADR
    - R-type (51) → EXECR
    - addi → EXECI
    - beq (99) → BEQ
    - jal → JAL
    - lui → LUI, auipc → AUIPC (EXT_OPS = 1 only)
    - otherwise → TRAP with fault_cause = 10
- MEMADR: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 00. Goes to MEMREAD if opcode = lw, else MEMWRITE.
- MEMREAD: mem_req = 1, AdrSrc = 1, ResultSrc = 00. Goes to MEMWB on mem_ready, else holds.
- MEMWB: ResultSrc = 01, RegWrite = 1. Goes to FETCH.
- MEMWRITE: mem_req = 1, AdrSrc = 1, MemWrite = 1. MemWrite is held through the wait; the write commits on mem_ready. Goes to FETCH on mem_ready.
- EXECR: ALUSrcA = 10, ALUSrcB = 00, ALUOp = 10. Goes to ALUWB.
- EXECI: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 10. Goes to ALUWB.
- ALUWB: ResultSrc = 00, RegWrite = 1. Goes to FETCH.
- BEQ: ALUSrcA = 10, ALUSrcB = 00, ALUOp = 01, ResultSrc = 00, Branch = 1. PCWrite = zero. Goes to FETCH.
- JAL: ALUSrcA = 01, ALUSrcB = 10, ALUOp = 00, ResultSrc = 00, PCUpdate = 1. Goes to ALUWB.
- LUI: ALUSrcA = 11, ALUSrcB = 01, ALUOp = 00. Goes to ALUWB.
- AUIPC: ALUSrcA = 01, ALUSrcB = 01, ALUOp = 00. Goes to ALUWB.
- Instruction latencies with zero wait states:
  - lw: 5 cycles
  - sw, R-type, addi, jal, lui, auipc: 4 cycles
  - beq: 3 cycles
- Wait counter:
  - wait_cnt increments each cycle in a mem_req state while mem_ready = 0.
  - It clears on any state change.
  - When MEM_TIMEOUT ≠ 0 and wait_cnt = MEM_TIMEOUT with mem_ready still 0, next state = TRAP and fault_cause = 01.
  - mem_ready = 1 in that same cycle wins: no trap.
- TRAP:
  - All enables are 0: PCWrite, IRWrite, RegWrite, MemWrite and mem_req.
  - fault = 1; fault_cause is held.
  - TRAP is exited only by rst.
- MEM_WAIT = 0: every mem_req state completes in 1 cycle and the timeout never fires.
- rst asserted mid-instruction (including mid-wait): the state returns to FETCH immediately and no further writes are asserted.

Test Plan:
- Reset, then lw (opcode 3) with mem_ready tied 1: state_dbg sequence 0,1,2,3,4,0. RegWrite = 1 only in state 4 with ResultSrc = 01.
- sw (35) with mem_ready low for 3 cycles in MEMWRITE: MemWrite = 1 for 4 cycles, then FETCH. ImmSrc = 001 throughout decode/execute.
- beq (99): with zero = 1, PCWrite = 1 in BEQ (3 cycles total). With zero = 0, PCWrite = 0 in BEQ.
- MEM_TIMEOUT = 4, mem_ready held 0 in FETCH: TRAP entered after 5 FETCH cycles, fault = 1, fault_cause = 01. It remains in TRAP until rst, then returns to state 0.
- opcode 7'd55 with EXT_OPS = 1: sequence 0,1,11,8,0 with ALUSrcA = 11 and ImmSrc = 100. With EXT_OPS = 0: DECODE → TRAP, fault_cause = 10.
- jal (111): JAL asserts PCWrite = 1, then ALUWB asserts RegWrite = 1. An rst pulse during ALUWB clears the state to 0 asynchronously and RegWrite drops the same cycle.
